// File: rtl/dense_layer_sequencer.sv
// Walks the single-port RAM through one fully connected layer, writes every saturated y[j] and reports the argmax.
// 1571 cycles per neuron, done pulse N_OUT*1571+1 cycles after the start cycle; start is ignored unless idle.
module dense_layer_sequencer #(
  parameter int                N_IN      = 784,
  parameter int                N_OUT     = 10,
  parameter int                ADDR_W    = 14,
  parameter int                DATA_W    = 24,
  parameter int                ACC_W     = 48,
  parameter int                OUT_SHIFT = 0,
  parameter logic [ADDR_W-1:0] X_BASE    = 14'h0000,
  parameter logic [ADDR_W-1:0] W_BASE    = 14'h1000,
  parameter logic [ADDR_W-1:0] B_BASE    = 14'h2EA0,
  parameter logic [ADDR_W-1:0] Y_BASE    = 14'h3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        class_out,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int I_W = $clog2(N_IN + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, LD_B, RD_X, RD_W, MAC_LAST, WR_Y, DONE} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               j_q, j_d;
  logic [I_W-1:0]           i_q, i_d;
  logic [ADDR_W-1:0]        w_ptr_q, w_ptr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, best_q, best_d;
  logic [7:0]               x_reg_q, x_reg_d;
  logic [3:0]               best_idx_q, best_idx_d, class_q, class_d;
  logic                     busy_q, busy_d, done_q, done_d, ram_en_q, ram_en_d;
  logic [3:0]               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;

  logic signed [ACC_W-1:0]  rdata_sx, x_sx, mac, shifted;
  logic [DATA_W-1:0]        sat_val;

  // rdata here always belongs to the read issued in the previous cycle
  assign rdata_sx = {{(ACC_W-DATA_W){ram_rdata[DATA_W-1]}}, ram_rdata};
  assign x_sx     = {{(ACC_W-8){1'b0}}, x_reg_q};
  assign mac      = acc_q + x_sx * rdata_sx;
  assign shifted  = mac >>> OUT_SHIFT;
  assign sat_val  = (shifted > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                    (shifted < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : shifted[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    i_d         = i_q;
    w_ptr_d     = w_ptr_q;
    acc_d       = acc_q;
    x_reg_d     = x_reg_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_d     = class_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'h0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LD_B;
          j_d        = 4'd0;
          w_ptr_d    = W_BASE;
          busy_d     = 1'b1;
          ram_en_d   = 1'b1;
          ram_addr_d = B_BASE;
        end
      end
      LD_B: begin
        state_d    = RD_X;
        i_d        = '0;
        ram_en_d   = 1'b1;
        ram_addr_d = X_BASE;
      end
      RD_X: begin
        acc_d      = (i_q == '0) ? rdata_sx : mac;
        state_d    = RD_W;
        ram_en_d   = 1'b1;
        ram_addr_d = w_ptr_q;
      end
      RD_W: begin
        x_reg_d = ram_rdata[7:0];
        w_ptr_d = w_ptr_q + 1'b1;
        if (i_q == I_W'(N_IN - 1)) begin
          state_d = MAC_LAST;
        end else begin
          i_d        = i_q + 1'b1;
          state_d    = RD_X;
          ram_en_d   = 1'b1;
          ram_addr_d = X_BASE + ADDR_W'(i_q + 1'b1);
        end
      end
      MAC_LAST: begin
        acc_d       = mac;
        state_d     = WR_Y;
        ram_en_d    = 1'b1;
        ram_we_d    = 4'hF;
        ram_addr_d  = Y_BASE + ADDR_W'(j_q);
        ram_wdata_d = sat_val;
      end
      WR_Y: begin
        // strict compare on the unshifted accumulator keeps the lowest index on ties
        if (j_q == 4'd0 || acc_q > best_q) begin
          best_d     = acc_q;
          best_idx_d = j_q;
        end
        if (j_q == 4'(N_OUT - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          class_d = best_idx_d;
        end else begin
          j_d        = j_q + 4'd1;
          state_d    = LD_B;
          ram_en_d   = 1'b1;
          ram_addr_d = B_BASE + ADDR_W'(j_q + 4'd1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      j_q         <= '0;
      i_q         <= '0;
      w_ptr_q     <= '0;
      acc_q       <= '0;
      x_reg_q     <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      i_q         <= i_d;
      w_ptr_q     <= w_ptr_d;
      acc_q       <= acc_d;
      x_reg_q     <= x_reg_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_q     <= class_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign class_out = class_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench for dense_layer_sequencer: RAM model plus an arithmetic reference for y[j] and the argmax.
module tb_dense_layer_sequencer;
  localparam int N_IN       = 784;
  localparam int N_OUT      = 10;
  localparam int RUN_CYCLES = N_OUT * (2 * N_IN + 3) + 1;
  localparam int X_BASE     = 'h0000;
  localparam int W_BASE     = 'h1000;
  localparam int B_BASE     = 'h2EA0;
  localparam int Y_BASE     = 'h3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, ram_en;
  logic [3:0]  class_out, ram_we;
  logic [13:0] ram_addr;
  logic [23:0] ram_wdata;
  logic [23:0] ram_rdata = 24'h0;

  logic [23:0] mem [0:16383];
  int          cyc = 0;
  int          checks = 0, passes = 0;
  int          start_cyc = 0, wr_cnt = 0, done_cnt = 0;
  logic [23:0] exp_y [0:N_OUT-1];
  logic [23:0] y_got [0:N_OUT-1];
  logic [3:0]  exp_cls = 4'd0;

  dense_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .class_out(class_out),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
  endtask

  function automatic longint sext(input logic [23:0] v);
    return v[23] ? longint'(v) - 64'sd16777216 : longint'(v);
  endfunction

  function automatic logic [23:0] sat(input longint a);
    if (a > 64'sd8388607) return 24'h7FFFFF;
    if (a < -64'sd8388608) return 24'h800000;
    return a[23:0];
  endfunction

  // Reference: direct sum over the RAM image, then saturation and a first-maximum search.
  task automatic model();
    longint acc, best;
    logic [23:0] xv;
    best = 0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = sext(mem[B_BASE + j]);
      for (int i = 0; i < N_IN; i++) begin
        xv = mem[X_BASE + i];
        acc += longint'(xv[7:0]) * sext(mem[W_BASE + j * N_IN + i]);
      end
      exp_y[j] = sat(acc);
      if (j == 0 || acc > best) begin
        best    = acc;
        exp_cls = 4'(j);
      end
    end
  endtask

  task automatic fill(input int kind);
    logic [23:0] w;
    for (int i = 0; i < N_IN; i++)
      case (kind)
        1, 3:    mem[X_BASE + i] = 24'd0;
        2:       mem[X_BASE + i] = 24'd1;
        4:       mem[X_BASE + i] = 24'd255;
        default: mem[X_BASE + i] = 24'($urandom_range(0, 255));
      endcase
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        case (kind)
          1, 3:    w = 24'($urandom);
          2:       w = (j == 3) ? 24'd1 : 24'd0;
          4:       w = (j == 5) ? 24'h7FFFFF : (j == 7) ? 24'hFFFFFF : 24'd0;
          default: w = 24'(int'($urandom_range(0, 80)) - 40);
        endcase
        mem[W_BASE + j * N_IN + i] = w;
      end
      case (kind)
        1:       mem[B_BASE + j] = 24'(16 * j);
        3:       mem[B_BASE + j] = 24'hFFFFF0;
        5:       mem[B_BASE + j] = 24'(int'($urandom_range(0, 2000000)) - 1000000);
        default: mem[B_BASE + j] = 24'd0;
      endcase
    end
  endtask

  // Per-cycle compare of the DUT against the reference, sampled on the falling edge.
  task automatic monitor();
    chk("busy_done_overlap", longint'(busy & done), 0);
    chk("ram_en_while_idle", longint'(!busy & ram_en), 0);
    if (ram_we != 4'h0) begin
      if (wr_cnt < N_OUT) begin
        chk("wr_we", ram_we, 'hF);
        chk("wr_addr", ram_addr, Y_BASE + wr_cnt);
        chk("wr_data", ram_wdata, exp_y[wr_cnt]);
        y_got[wr_cnt] = ram_wdata;
      end else begin
        chk("wr_extra", wr_cnt + 1, N_OUT);
      end
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      chk("done_class", class_out, exp_cls);
      chk("done_latency", cyc - start_cyc, RUN_CYCLES);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int abort_at, input bit extra);
    bit fin;
    fin      = 1'b0;
    wr_cnt   = 0;
    done_cnt = 0;
    for (int k = 0; k < N_OUT; k++) y_got[k] = 24'hDEAD5A;
    start     = 1'b1;
    start_cyc = cyc;
    for (int n = 1; n <= RUN_CYCLES + 100 && !fin; n++) begin
      cycle();
      start = extra && (n == 10 || n == 8000);
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_ram_en", ram_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ram_we", ram_we, 0);
        fin = 1'b1;
      end else if (done_cnt != 0) begin
        fin = 1'b1;
      end
    end
    if (abort_at > 0) begin
      repeat (3) cycle();
      chk("abort_writes", wr_cnt, 0);
      chk("abort_done", done_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      chk("done_seen", done_cnt, 1);
      repeat (20) cycle();
      chk("done_single", done_cnt, 1);
      chk("write_count", wr_cnt, N_OUT);
      chk("class_held", class_out, exp_cls);
    end
  endtask

  task automatic check_y(input string tag, input int j, input logic [23:0] v);
    chk({tag, "_model"}, exp_y[j], v);
    chk({tag, "_dut"}, y_got[j], v);
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = 24'($urandom);
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_class", class_out, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) cycle();

    fill(1); model(); run_job(0, 1'b0);
    for (int j = 0; j < N_OUT; j++) check_y("bias_only_y", j, 24'(16 * j));
    chk("bias_only_class_model", exp_cls, 9);
    chk("bias_only_class_dut", class_out, 9);

    fill(3); model(); run_job(0, 1'b0);
    for (int j = 0; j < N_OUT; j++) check_y("ties_y", j, 24'hFFFFF0);
    chk("ties_class_dut", class_out, 0);

    fill(4); model(); run_job(0, 1'b0);
    check_y("sat_y5", 5, 24'h7FFFFF);
    check_y("sat_y7", 7, 24'hFCF310);
    check_y("sat_y0", 0, 24'h000000);
    chk("sat_class_dut", class_out, 5);

    fill(5); model(); run_job(0, 1'b0);

    fill(2); model(); run_job(500, 1'b0);
    run_job(0, 1'b1);
    for (int j = 0; j < N_OUT; j++) check_y("hot_row_y", j, (j == 3) ? 24'd784 : 24'd0);
    chk("hot_row_class_dut", class_out, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
